// File: rtl/kv_cmd_queue.sv
// kv_cmd_queue: command front-end for the cache core. Buffers READ/UPSERT/DELETE
// commands, issues them to the core one at a time over its ready/succ handshake
// and queues the results (success, read data, timeout error) for the agent.
module kv_cmd_queue #(
    parameter int KEY_WIDTH      = 16,
    parameter int VALUE_WIDTH    = 64,
    parameter int CMD_DEPTH      = 4,
    parameter int RSP_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic [1:0]             cmd_op_i,
    input  logic [KEY_WIDTH-1:0]   cmd_key_i,
    input  logic [VALUE_WIDTH-1:0] cmd_value_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic                   rsp_succ_o,
    output logic                   rsp_err_o,
    output logic [VALUE_WIDTH-1:0] rsp_value_o,
    output logic [1:0]             core_op_o,
    output logic [KEY_WIDTH-1:0]   core_key_o,
    output logic [VALUE_WIDTH-1:0] core_value_o,
    input  logic                   core_rdy_i,
    input  logic                   core_succ_i,
    input  logic [VALUE_WIDTH-1:0] core_value_i,
    output logic                   busy_o
);

    localparam int CPW = $clog2(CMD_DEPTH);
    localparam int RPW = $clog2(RSP_DEPTH);
    localparam int CCW = $clog2(CMD_DEPTH + 1);
    localparam int RCW = $clog2(RSP_DEPTH + 1);
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CCW-1:0] CMD_FULL    = CCW'(CMD_DEPTH);
    localparam logic [RCW-1:0] RSP_FULL    = RCW'(RSP_DEPTH);
    localparam logic [TW-1:0]  TIMEOUT_VAL = TW'(TIMEOUT_CYCLES);
    localparam logic [1:0]     OP_NOP      = 2'd0;
    localparam logic [1:0]     OP_READ     = 2'd1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // command FIFO
    logic [1:0]             cmd_op_mem    [CMD_DEPTH];
    logic [KEY_WIDTH-1:0]   cmd_key_mem   [CMD_DEPTH];
    logic [VALUE_WIDTH-1:0] cmd_value_mem [CMD_DEPTH];
    logic [CPW-1:0]         cmd_wr_ptr, cmd_rd_ptr;
    logic [CCW-1:0]         cmd_count;
    logic                   cmd_push, cmd_pop;

    // response FIFO
    logic                   rsp_succ_mem  [RSP_DEPTH];
    logic                   rsp_err_mem   [RSP_DEPTH];
    logic [VALUE_WIDTH-1:0] rsp_value_mem [RSP_DEPTH];
    logic [RPW-1:0]         rsp_wr_ptr, rsp_rd_ptr;
    logic [RCW-1:0]         rsp_count;
    logic                   rsp_push, rsp_wr_en, rsp_pop;
    logic                   rsp_push_succ, rsp_push_err;
    logic [VALUE_WIDTH-1:0] rsp_push_value;

    // in-flight operation tracking
    logic [1:0]             op_q;
    logic [TW-1:0]          timer_q;
    logic                   seen_busy_q;

    // Ready depends only on the registered count, so a full FIFO stays not-ready
    // even in the cycle its head is being popped. NOP handshakes are dropped here.
    assign cmd_ready_o = (cmd_count < CMD_FULL);
    assign cmd_push    = cmd_valid_i && cmd_ready_o && (cmd_op_i != OP_NOP);

    assign rsp_valid_o = (rsp_count != '0);
    assign rsp_pop     = rsp_valid_o && rsp_ready_i;
    assign rsp_wr_en   = rsp_push && ((rsp_count < RSP_FULL) || rsp_pop);
    assign rsp_succ_o  = rsp_valid_o & rsp_succ_mem[rsp_rd_ptr];
    assign rsp_err_o   = rsp_valid_o & rsp_err_mem[rsp_rd_ptr];
    assign rsp_value_o = rsp_valid_o ? rsp_value_mem[rsp_rd_ptr] : '0;

    assign core_op_o = (state_q == ST_ISSUE) ? op_q : OP_NOP;
    assign busy_o    = (state_q != ST_IDLE);

    // Command storage; contents need no reset because count/pointers guard them.
    always_ff @(posedge clk) begin
        if (cmd_push) begin
            cmd_op_mem[cmd_wr_ptr]    <= cmd_op_i;
            cmd_key_mem[cmd_wr_ptr]   <= cmd_key_i;
            cmd_value_mem[cmd_wr_ptr] <= cmd_value_i;
        end
    end

    // Command FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_wr_ptr <= '0;
            cmd_rd_ptr <= '0;
            cmd_count  <= '0;
        end else begin
            if (cmd_push) cmd_wr_ptr <= cmd_wr_ptr + 1'b1;
            if (cmd_pop)  cmd_rd_ptr <= cmd_rd_ptr + 1'b1;
            case ({cmd_push, cmd_pop})
                2'b10:   cmd_count <= cmd_count + 1'b1;
                2'b01:   cmd_count <= cmd_count - 1'b1;
                default: cmd_count <= cmd_count;
            endcase
        end
    end

    // Response storage; outputs are gated by rsp_valid_o so stale slots never show.
    always_ff @(posedge clk) begin
        if (rsp_wr_en) begin
            rsp_succ_mem[rsp_wr_ptr]  <= rsp_push_succ;
            rsp_err_mem[rsp_wr_ptr]   <= rsp_push_err;
            rsp_value_mem[rsp_wr_ptr] <= rsp_push_value;
        end
    end

    // Response FIFO pointers and occupancy; push and pop may coincide even when full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_wr_ptr <= '0;
            rsp_rd_ptr <= '0;
            rsp_count  <= '0;
        end else begin
            if (rsp_wr_en) rsp_wr_ptr <= rsp_wr_ptr + 1'b1;
            if (rsp_pop)   rsp_rd_ptr <= rsp_rd_ptr + 1'b1;
            case ({rsp_wr_en, rsp_pop})
                2'b10:   rsp_count <= rsp_count + 1'b1;
                2'b01:   rsp_count <= rsp_count - 1'b1;
                default: rsp_count <= rsp_count;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic: issue only when a response slot is guaranteed, then wait
    // for the core to go busy and come back; completion beats timeout.
    always_comb begin
        state_d        = state_q;
        cmd_pop        = 1'b0;
        rsp_push       = 1'b0;
        rsp_push_succ  = 1'b0;
        rsp_push_err   = 1'b0;
        rsp_push_value = '0;
        case (state_q)
            ST_IDLE: begin
                if ((cmd_count != '0) && core_rdy_i && (rsp_count < RSP_FULL)) begin
                    cmd_pop = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (seen_busy_q && core_rdy_i) begin
                    rsp_push       = 1'b1;
                    rsp_push_succ  = core_succ_i;
                    rsp_push_value = (op_q == OP_READ) ? core_value_i : '0;
                    state_d        = ST_IDLE;
                end else if (timer_q == TIMEOUT_VAL) begin
                    rsp_push     = 1'b1;
                    rsp_push_err = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Latch the popped command and track busy/timeout for the operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q         <= OP_NOP;
            core_key_o   <= '0;
            core_value_o <= '0;
            timer_q      <= '0;
            seen_busy_q  <= 1'b0;
        end else begin
            if (cmd_pop) begin
                op_q         <= cmd_op_mem[cmd_rd_ptr];
                core_key_o   <= cmd_key_mem[cmd_rd_ptr];
                core_value_o <= cmd_value_mem[cmd_rd_ptr];
            end
            if (state_q == ST_ISSUE) begin
                timer_q     <= '0;
                seen_busy_q <= 1'b0;
            end else if (state_q == ST_WAIT) begin
                if (timer_q != TIMEOUT_VAL) timer_q <= timer_q + 1'b1;
                if (!core_rdy_i)            seen_busy_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_kv_cmd_queue.sv
// tb_kv_cmd_queue: scoreboard bench for kv_cmd_queue with a behavioural core
// model (small key/value store) that drops ready after each op and raises it later.
module tb_kv_cmd_queue;

    localparam int KW = 16;
    localparam int VW = 64;
    localparam logic [1:0] OP_NOP = 2'd0, OP_READ = 2'd1, OP_UPSERT = 2'd2, OP_DELETE = 2'd3;
    localparam logic [VW-1:0] JUNK = 64'hDEAD_BEEF_CAFE_F00D;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid_i, cmd_ready_o;
    logic [1:0]    cmd_op_i;
    logic [KW-1:0] cmd_key_i;
    logic [VW-1:0] cmd_value_i;
    logic          rsp_valid_o, rsp_ready_i, rsp_succ_o, rsp_err_o;
    logic [VW-1:0] rsp_value_o;
    logic [1:0]    core_op_o;
    logic [KW-1:0] core_key_o;
    logic [VW-1:0] core_value_o;
    logic          core_rdy_i, core_succ_i;
    logic [VW-1:0] core_value_i;
    logic          busy_o;

    typedef struct packed {
        logic          succ;
        logic          err;
        logic [VW-1:0] value;
    } rsp_t;

    rsp_t          sb[$];
    logic [VW-1:0] ref_mem  [logic [KW-1:0]];
    logic [VW-1:0] core_mem [logic [KW-1:0]];
    int            n_compared   = 0;
    int            n_mismatched = 0;
    int            issue_count  = 0;
    bit            core_block   = 1'b0;
    bit            core_hang    = 1'b0;

    kv_cmd_queue dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_op_i    (cmd_op_i),
        .cmd_key_i   (cmd_key_i),
        .cmd_value_i (cmd_value_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_succ_o  (rsp_succ_o),
        .rsp_err_o   (rsp_err_o),
        .rsp_value_o (rsp_value_o),
        .core_op_o   (core_op_o),
        .core_key_o  (core_key_o),
        .core_value_o(core_value_o),
        .core_rdy_i  (core_rdy_i),
        .core_succ_i (core_succ_i),
        .core_value_i(core_value_i),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    // Count cycles in which an operation is presented to the core.
    initial begin
        forever begin
            @(negedge clk);
            if (core_op_o != OP_NOP) issue_count++;
        end
    end

    // Core model: sees op, goes busy next cycle, answers three cycles later.
    initial begin
        logic [1:0]    m_op;
        logic [KW-1:0] m_key;
        logic [VW-1:0] m_val;
        core_rdy_i   = 1'b1;
        core_succ_i  = 1'b0;
        core_value_i = JUNK;
        forever begin
            @(negedge clk);
            if (core_block) begin
                core_rdy_i = 1'b0;
            end else if (core_op_o != OP_NOP) begin
                m_op  = core_op_o;
                m_key = core_key_o;
                m_val = core_value_o;
                @(negedge clk);
                core_rdy_i = 1'b0;
                if (core_hang) begin
                    while (core_hang) @(negedge clk);
                    core_succ_i  = 1'b0;
                    core_value_i = JUNK;
                end else begin
                    repeat (3) @(negedge clk);
                    core_value_i = JUNK;
                    case (m_op)
                        OP_READ: begin
                            core_succ_i  = core_mem.exists(m_key);
                            core_value_i = core_mem.exists(m_key) ? core_mem[m_key] : '0;
                        end
                        OP_UPSERT: begin
                            core_mem[m_key] = m_val;
                            core_succ_i     = 1'b1;
                        end
                        default: begin
                            core_succ_i = core_mem.exists(m_key);
                            if (core_mem.exists(m_key)) core_mem.delete(m_key);
                        end
                    endcase
                end
                core_rdy_i = 1'b1;
            end else begin
                core_rdy_i = 1'b1;
            end
        end
    end

    // Reference store: expected response of a command that completes normally.
    function automatic rsp_t ref_apply(input logic [1:0] op, input logic [KW-1:0] key,
                                       input logic [VW-1:0] val);
        rsp_t r;
        r = '0;
        case (op)
            OP_READ: begin
                r.succ  = ref_mem.exists(key);
                r.value = ref_mem.exists(key) ? ref_mem[key] : '0;
            end
            OP_UPSERT: begin
                ref_mem[key] = val;
                r.succ       = 1'b1;
            end
            default: begin
                r.succ = ref_mem.exists(key);
                if (ref_mem.exists(key)) ref_mem.delete(key);
            end
        endcase
        return r;
    endfunction

    // Drive one command until accepted; called and returns at a negedge.
    task automatic send_cmd(input logic [1:0] op, input logic [KW-1:0] key, input logic [VW-1:0] val);
        int waited = 0;
        cmd_valid_i = 1'b1;
        cmd_op_i    = op;
        cmd_key_i   = key;
        cmd_value_i = val;
        while (!cmd_ready_o && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        n_compared++;
        if (cmd_ready_o !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL cmd_accept: op=%0d key=%h not accepted after %0d cycles, required acceptance",
                     op, key, waited);
        end else begin
            @(negedge clk);
        end
        cmd_valid_i = 1'b0;
        cmd_op_i    = OP_NOP;
    endtask

    // Pop n responses and compare each against the scoreboard head.
    task automatic drain_rsp(input int n, input string tag);
        int   got    = 0;
        int   cycles = 0;
        rsp_t exp;
        rsp_ready_i = 1'b1;
        while (got < n && cycles < 400) begin
            if (rsp_valid_o) begin
                n_compared++;
                if (sb.size() == 0) begin
                    n_mismatched++;
                    $display("[TB] FAIL %s: unexpected response succ=%0b err=%0b value=%h, none required",
                             tag, rsp_succ_o, rsp_err_o, rsp_value_o);
                end else begin
                    exp = sb.pop_front();
                    if (rsp_succ_o !== exp.succ || rsp_err_o !== exp.err || rsp_value_o !== exp.value) begin
                        n_mismatched++;
                        $display("[TB] FAIL %s: got succ=%0b err=%0b value=%h, required succ=%0b err=%0b value=%h",
                                 tag, rsp_succ_o, rsp_err_o, rsp_value_o, exp.succ, exp.err, exp.value);
                    end
                end
                got++;
            end
            @(negedge clk);
            cycles++;
        end
        rsp_ready_i = 1'b0;
        if (got < n) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL %s_timeout: got %0d responses, required %0d", tag, got, n);
        end
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_op_i    = OP_NOP;
        cmd_key_i   = '0;
        cmd_value_i = '0;
        rsp_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        n_compared++;
        if ({cmd_ready_o, rsp_valid_o, rsp_succ_o, rsp_err_o, busy_o, core_op_o} !== 7'b1000000) begin
            n_mismatched++;
            $display("[TB] FAIL reset_flags: got %b, required 1000000",
                     {cmd_ready_o, rsp_valid_o, rsp_succ_o, rsp_err_o, busy_o, core_op_o});
        end
        n_compared++;
        if ({core_key_o, core_value_o, rsp_value_o} !== '0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_data: got key=%h value=%h rsp_value=%h, required all 0",
                     core_key_o, core_value_o, rsp_value_o);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_compared++;
        if (cmd_ready_o !== 1'b1 || rsp_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_release: got ready=%0b valid=%0b busy=%0b, required 1 0 0",
                     cmd_ready_o, rsp_valid_o, busy_o);
        end
    endtask

    task automatic test_upsert();
        int start = issue_count;
        int n     = 0;
        send_cmd(OP_UPSERT, 16'h00A5, 64'h1122334455667788);
        sb.push_back(ref_apply(OP_UPSERT, 16'h00A5, 64'h1122334455667788));
        n_compared++;
        if (core_op_o !== OP_NOP) begin
            n_mismatched++;
            $display("[TB] FAIL upsert_early_op: got core_op=%0d, required 0 in decision cycle", core_op_o);
        end
        @(negedge clk);
        n_compared++;
        if (core_op_o !== OP_UPSERT || busy_o !== 1'b1 || core_key_o !== 16'h00A5 ||
            core_value_o !== 64'h1122334455667788) begin
            n_mismatched++;
            $display("[TB] FAIL upsert_issue: got op=%0d busy=%0b key=%h value=%h, required 2 1 00a5 1122334455667788",
                     core_op_o, busy_o, core_key_o, core_value_o);
        end
        @(negedge clk);
        n_compared++;
        if (core_op_o !== OP_NOP || busy_o !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL upsert_wait: got op=%0d busy=%0b, required 0 1", core_op_o, busy_o);
        end
        while (!rsp_valid_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        n_compared++;
        if (n != 4) begin
            n_mismatched++;
            $display("[TB] FAIL upsert_latency: response after %0d cycles, required 4", n);
        end
        drain_rsp(1, "upsert_rsp");
        n_compared++;
        if (issue_count - start != 1) begin
            n_mismatched++;
            $display("[TB] FAIL upsert_op_cycles: got %0d op cycles, required 1", issue_count - start);
        end
    endtask

    task automatic test_read_delete();
        send_cmd(OP_READ, 16'h00A5, 64'h0);
        sb.push_back(ref_apply(OP_READ, 16'h00A5, 64'h0));
        drain_rsp(1, "read_hit");
        send_cmd(OP_DELETE, 16'h0BAD, 64'h5555);
        sb.push_back(ref_apply(OP_DELETE, 16'h0BAD, 64'h5555));
        drain_rsp(1, "delete_miss");
    endtask

    task automatic test_back_to_back();
        bit ready_seen = 1'b0;
        core_block = 1'b1;
        repeat (2) @(negedge clk);
        send_cmd(OP_NOP, 16'h0011, 64'h0);
        send_cmd(OP_UPSERT, 16'h0011, 64'hA0A0_0000_0000_0001);
        sb.push_back(ref_apply(OP_UPSERT, 16'h0011, 64'hA0A0_0000_0000_0001));
        send_cmd(OP_READ, 16'h0011, 64'h0);
        sb.push_back(ref_apply(OP_READ, 16'h0011, 64'h0));
        send_cmd(OP_DELETE, 16'h0011, 64'h0);
        sb.push_back(ref_apply(OP_DELETE, 16'h0011, 64'h0));
        n_compared++;
        if (cmd_ready_o !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL nop_not_stored: got ready=%0b after 3 commands, required 1", cmd_ready_o);
        end
        send_cmd(OP_READ, 16'h0011, 64'h0);
        sb.push_back(ref_apply(OP_READ, 16'h0011, 64'h0));
        n_compared++;
        if (cmd_ready_o !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL fifo_full: got ready=%0b after 4 commands, required 0", cmd_ready_o);
        end
        cmd_valid_i = 1'b1;
        cmd_op_i    = OP_DELETE;
        cmd_key_i   = 16'h0011;
        repeat (3) begin
            if (cmd_ready_o) ready_seen = 1'b1;
            @(negedge clk);
        end
        n_compared++;
        if (ready_seen !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL fifth_waits: got ready=1 while full, required 0");
        end
        core_block = 1'b0;
        send_cmd(OP_DELETE, 16'h0011, 64'h0);
        sb.push_back(ref_apply(OP_DELETE, 16'h0011, 64'h0));
        drain_rsp(5, "b2b_rsp");
    endtask

    task automatic test_timeout();
        int   n = 0;
        rsp_t e;
        core_hang = 1'b1;
        send_cmd(OP_READ, 16'h00A5, 64'h0);
        e = '0;
        e.err = 1'b1;
        sb.push_back(e);
        while (!rsp_valid_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        n_compared++;
        if (n < 66 || n > 67 || busy_o !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL timeout_latency: error after %0d cycles busy=%0b, required 66..67 and 0", n, busy_o);
        end
        drain_rsp(1, "timeout_rsp");
        core_hang = 1'b0;
        repeat (2) @(negedge clk);
        send_cmd(OP_UPSERT, 16'h0022, 64'h0000_2222_0000_2222);
        sb.push_back(ref_apply(OP_UPSERT, 16'h0022, 64'h0000_2222_0000_2222));
        drain_rsp(1, "after_timeout");
    endtask

    task automatic test_rsp_backpressure();
        int start = issue_count;
        for (int i = 0; i < 5; i++) begin
            send_cmd(OP_UPSERT, KW'(16'h0030 + i), VW'(64'h3300 + i));
            sb.push_back(ref_apply(OP_UPSERT, KW'(16'h0030 + i), VW'(64'h3300 + i)));
        end
        repeat (80) @(negedge clk);
        n_compared++;
        if (issue_count - start != 4 || rsp_valid_o !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL rsp_full_stall: got %0d issues valid=%0b, required 4 1",
                     issue_count - start, rsp_valid_o);
        end
        repeat (5) @(negedge clk);
        n_compared++;
        if (rsp_succ_o !== sb[0].succ || rsp_err_o !== sb[0].err || rsp_value_o !== sb[0].value) begin
            n_mismatched++;
            $display("[TB] FAIL rsp_hold: got succ=%0b err=%0b value=%h, required succ=%0b err=%0b value=%h",
                     rsp_succ_o, rsp_err_o, rsp_value_o, sb[0].succ, sb[0].err, sb[0].value);
        end
        drain_rsp(5, "backpressure_rsp");
        n_compared++;
        if (issue_count - start != 5) begin
            n_mismatched++;
            $display("[TB] FAIL rsp_resume: got %0d issues, required 5", issue_count - start);
        end
    endtask

    task automatic test_reset_midop();
        int n     = 0;
        int start;
        bit stale = 1'b0;
        core_hang = 1'b1;
        for (int i = 0; i < 3; i++) send_cmd(OP_READ, KW'(16'h0040 + i), 64'h0);
        while (!busy_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_compared++;
        if ({cmd_ready_o, rsp_valid_o, rsp_succ_o, rsp_err_o, busy_o, core_op_o} !== 7'b1000000) begin
            n_mismatched++;
            $display("[TB] FAIL midop_reset_flags: got %b, required 1000000",
                     {cmd_ready_o, rsp_valid_o, rsp_succ_o, rsp_err_o, busy_o, core_op_o});
        end
        n_compared++;
        if ({core_key_o, core_value_o, rsp_value_o} !== '0) begin
            n_mismatched++;
            $display("[TB] FAIL midop_reset_data: got key=%h value=%h rsp_value=%h, required all 0",
                     core_key_o, core_value_o, rsp_value_o);
        end
        core_hang = 1'b0;
        repeat (3) @(negedge clk);
        rst_n       = 1'b1;
        rsp_ready_i = 1'b1;
        start       = issue_count;
        repeat (30) begin
            @(negedge clk);
            if (rsp_valid_o) stale = 1'b1;
        end
        rsp_ready_i = 1'b0;
        n_compared++;
        if (stale !== 1'b0 || issue_count != start) begin
            n_mismatched++;
            $display("[TB] FAIL midop_no_stale: got stale=%0b issues=%0b, required 0 0",
                     stale, issue_count != start);
        end
        send_cmd(OP_UPSERT, 16'h0050, 64'h5050_5050_5050_5050);
        sb.push_back(ref_apply(OP_UPSERT, 16'h0050, 64'h5050_5050_5050_5050));
        drain_rsp(1, "after_reset");
    endtask

    // Watchdog so a stuck run still ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Test sequence.
    initial begin
        test_reset();
        test_upsert();
        test_read_delete();
        test_back_to_back();
        test_timeout();
        test_rsp_backpressure();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/kv_cmd_queue.md
Name: kv_cmd_queue

Overview:
- Command front-end placed directly upstream of the cache core (controller + memory_block).
- Buffers key-value operations (READ / UPSERT / DELETE) from the bus-side agent in a command FIFO.
- Issues them to the core one at a time using the core's ready/op_succ handshake.
- Queues the results (success, read value, timeout error) in a response FIFO for the agent to drain.

Parameters:
- KEY_WIDTH, 16, key bits per command.
- VALUE_WIDTH, 64, value bits per command and response.
- CMD_DEPTH, 4, command FIFO entries (power of two, >=2).
- RSP_DEPTH, 4, response FIFO entries (power of two, >=2).
- TIMEOUT_CYCLES, 64, maximum cycles from issue to completion before an error response.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid_i  in  1  command offered.
- cmd_ready_o  out  1  command FIFO not full.
- cmd_op_i  in  2  0=NOP, 1=READ, 2=UPSERT, 3=DELETE.
- cmd_key_i  in  KEY_WIDTH  command key.
- cmd_value_i  in  VALUE_WIDTH  write value; used only by UPSERT.
- rsp_valid_o  out  1  response FIFO not empty.
- rsp_ready_i  in  1  response consumed.
- rsp_succ_o  out  1  core reported success.
- rsp_err_o  out  1  timeout occurred.
- rsp_value_o  out  VALUE_WIDTH  read data; 0 for non-READ and error responses.
- core_op_o  out  2  operation to core, same encoding as cmd_op_i.
- core_key_o  out  KEY_WIDTH  key to core.
- core_value_o  out  VALUE_WIDTH  value to core.
- core_rdy_i  in  1  core idle.
- core_succ_i  in  1  core operation success.
- core_value_i  in  VALUE_WIDTH  core read data.
- busy_o  out  1  operation in flight.

Behaviour:
- Reset (asynchronous, rst_n=0): both FIFOs empty, FSM=IDLE, timeout counter 0, seen_busy flag 0. Outputs: cmd_ready_o=1, rsp_valid_o=0, rsp_succ_o=0, rsp_err_o=0, rsp_value_o=0, core_op_o=NOP, core_key_o=0, core_value_o=0, busy_o=0.
- Reset mid-operation drops all queued and in-flight commands; no response is produced for them.

Command FIFO:
- Push when cmd_valid_i && cmd_ready_o && cmd_op_i!=NOP.
- A NOP handshake completes normally but is discarded: no entry, no response.
- cmd_ready_o = (count < CMD_DEPTH), derived from registered count only. When full, ready stays 0 even in a cycle where the head is popped.

Response FIFO:
- Pop when rsp_valid_o && rsp_ready_i.
- Simultaneous push and pop is allowed at any fill level, including full.
- rsp_* outputs show the head entry and hold stable while rsp_valid_o=1 && rsp_ready_i=0.

FSM states:
- IDLE:
  - Moves to ISSUE when the command FIFO is non-empty, core_rdy_i=1, and the response FIFO count < RSP_DEPTH.
  - On that transition the head is popped and its op/key/value are latched into core_key_o/core_value_o plus an op register.
- ISSUE (1 cycle):
  - core_op_o = latched op; core_op_o is NOP in every other cycle.
  - busy_o=1; counter cleared; seen_busy cleared. Next state WAIT.
- WAIT:
  - busy_o=1; counter increments each cycle; core_key_o/core_value_o held.
  - core_rdy_i=0 sets seen_busy.
  - Completion is the first cycle with seen_busy=1 && core_rdy_i=1. That cycle pushes {succ=core_succ_i, err=0, value = (op==READ) ? core_value_i : 0} and goes to IDLE.
  - Timeout: if the counter reaches TIMEOUT_CYCLES without completion, push {succ=0, err=1, value=0} and go to IDLE. Completion takes priority in the same cycle.
- Latency:
  - Command accepted at cycle t into an empty FIFO with an idle core: IDLE→ISSUE decision at t+1, core_op_o driven at t+2.
  - Response visible (rsp_valid_o) the cycle after the completion cycle.
- Ordering: strictly one in flight; responses leave in command order.
- A new IDLE→ISSUE decision may occur in the cycle immediately after a completion push, if all conditions hold.
- Widths: op fixed at 2 bits; counter width $clog2(TIMEOUT_CYCLES+1); no arithmetic on key/value.

Test Plan:
- Reset release, queue UPSERT key=0x00A5 val=0x1122334455667788; core model drops rdy 1 cycle after op, raises it 3 cycles later with succ=1 → core_op_o=2 for exactly one cycle; response succ=1, err=0, value=0.
- READ key=0x00A5 with core returning core_value_i=0x1122334455667788, succ=1 → rsp_value_o=0x1122334455667788; DELETE of a missing key with succ=0 → rsp_succ_o=0, err=0.
- Push 5 commands back-to-back with core_rdy_i held 0 → cmd_ready_o=0 after the 4th, the 5th waits; after core_rdy_i=1 all 5 responses arrive in order.
- Core never raises rdy after dropping it → error response {succ=0, err=1, value=0} after 64 cycles in WAIT; the next command then issues normally.
- rsp_ready_i=0 with 4 completed responses queued → no further issue (core_op_o stays NOP) until one is popped; NOP command with cmd_valid_i=1 → handshake completes, no response.
- Assert rst_n=0 during WAIT with 2 commands queued → all outputs return to reset values immediately; no stale response after release.
